// File: rtl/fpu_operand_issue.sv
// Issue stage for the single-precision add/sub datapath: operand FIFO, registered
// output slot, IEEE-754 special-operand classification and a sticky invalid flag.
module fpu_operand_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_32_a,
  input  logic [31:0]              i_32_b,
  input  logic                     i_add_sub,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_32_a,
  output logic [31:0]              o_32_b,
  output logic                     o_add_sub,
  output logic                     o_bypass,
  output logic [31:0]              o_32_bypass,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_inv_flag,
  input  logic                     i_clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [31:0]   QNAN      = 32'h7FC0_0000;
  localparam logic          SLOT_EMPTY = 1'b0;
  localparam logic          SLOT_HELD  = 1'b1;

  // Each entry is {add_sub, a, b}
  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          ready_reg;
  logic          state_reg;
  logic [31:0]   a_reg, b_reg, bypass_res_reg;
  logic          add_sub_reg, bypass_reg, inv_flag_reg;

  logic          push, load;
  logic [64:0]   head;
  logic [31:0]   head_a, head_b;
  logic          head_op, sb;
  logic [31:0]   opnd [2];
  logic [1:0]    op_zero, op_inf, op_nan;
  logic          cls_bypass, cls_inv;
  logic [31:0]   cls_result;

  assign push = i_valid && ready_reg;
  assign load = (count_reg != '0) && ((state_reg == SLOT_EMPTY) || i_ready);

  assign head    = mem[rd_ptr_reg];
  assign head_op = head[64];
  assign head_a  = head[63:32];
  assign head_b  = head[31:0];
  assign opnd[0] = head_a;
  assign opnd[1] = head_b;

  // Denormals share the zero class: the datapath flushes them.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cls
    assign op_zero[gi] = (opnd[gi][30:23] == 8'h00);
    assign op_inf[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] == 23'd0);
    assign op_nan[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] != 23'd0);
  end

  always_comb begin
    sb         = head_b[31] ^ head_op;
    cls_bypass = 1'b1;
    cls_inv    = 1'b0;
    cls_result = '0;
    if (|op_nan) begin
      cls_result = QNAN;
    end else if ((&op_inf) && (head_a[31] != sb)) begin
      cls_result = QNAN;
      cls_inv    = 1'b1;
    end else if (op_inf[0]) begin
      cls_result = {head_a[31], 8'hFF, 23'd0};
    end else if (op_inf[1]) begin
      cls_result = {sb, 8'hFF, 23'd0};
    end else if (&op_zero) begin
      cls_result = {head_a[31] & sb, 31'd0};
    end else if (op_zero[0]) begin
      cls_result = {sb, head_b[30:0]};
    end else if (op_zero[1]) begin
      cls_result = head_a;
    end else begin
      cls_bypass = 1'b0;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !load)
      count_next = count_reg + CNT_ONE;
    else if (!push && load)
      count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr_reg] <= {i_add_sub, i_32_a, i_32_b};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      ready_reg      <= 1'b1;
      state_reg      <= SLOT_EMPTY;
      a_reg          <= '0;
      b_reg          <= '0;
      add_sub_reg    <= 1'b0;
      bypass_reg     <= 1'b0;
      bypass_res_reg <= '0;
      inv_flag_reg   <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (load)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      // Ready is precomputed from next occupancy so a full FIFO never accepts.
      ready_reg <= (count_next < DEPTH_CNT);
      if (load) begin
        state_reg      <= SLOT_HELD;
        a_reg          <= head_a;
        b_reg          <= head_b;
        add_sub_reg    <= head_op;
        bypass_reg     <= cls_bypass;
        bypass_res_reg <= cls_result;
      end else if (i_ready) begin
        state_reg <= SLOT_EMPTY;
      end
      if (load && cls_inv)
        inv_flag_reg <= 1'b1;
      else if (i_clr_flags)
        inv_flag_reg <= 1'b0;
    end
  end

  assign o_ready     = ready_reg;
  assign o_valid     = state_reg;
  assign o_32_a      = a_reg;
  assign o_32_b      = b_reg;
  assign o_add_sub   = add_sub_reg;
  assign o_bypass    = bypass_reg;
  assign o_32_bypass = bypass_res_reg;
  assign o_count     = count_reg;
  assign o_inv_flag  = inv_flag_reg;

endmodule

// File: tb/tb_fpu_operand_issue.sv
// Bench for fpu_operand_issue: classification vector table, directed handshake
// sequences and a randomized run against a queue-based reference model.
module tb_fpu_operand_issue;
  localparam int DEPTH = 4;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_ready, i_add_sub, i_clr_flags;
  logic [31:0] i_32_a, i_32_b;
  logic        o_ready, o_valid, o_add_sub, o_bypass, o_inv_flag;
  logic [31:0] o_32_a, o_32_b, o_32_bypass;
  logic [$clog2(DEPTH):0] o_count;

  always #5 clk = ~clk;

  fpu_operand_issue #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_32_a(i_32_a), .i_32_b(i_32_b), .i_add_sub(i_add_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_32_a(o_32_a), .o_32_b(o_32_b),
    .o_add_sub(o_add_sub), .o_bypass(o_bypass), .o_32_bypass(o_32_bypass),
    .o_count(o_count), .o_inv_flag(o_inv_flag), .i_clr_flags(i_clr_flags)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        byp;
    logic [31:0] res;
    logic        inv;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
  } beat_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference classification from operand categories: 0 zero, 1 normal, 2 inf, 3 nan.
  function automatic int cls_of(input logic [31:0] x);
    logic [7:0]  e = x[30:23];
    logic [22:0] m = x[22:0];
    if (e == 8'h00) return 0;
    if (e != 8'hFF) return 1;
    return (m == 0) ? 2 : 3;
  endfunction

  function automatic void ref_cls(input logic [31:0] a, input logic [31:0] b, input logic op,
                                  output logic byp, output logic [31:0] res, output logic inv);
    int   ca = cls_of(a);
    int   cb = cls_of(b);
    logic sb = b[31] ^ op;
    byp = 1'b1;
    inv = 1'b0;
    res = 32'd0;
    if (ca == 3 || cb == 3) res = QNAN;
    else if (ca == 2 && cb == 2) begin
      if (a[31] != sb) begin res = QNAN; inv = 1'b1; end
      else res = {a[31], 8'hFF, 23'd0};
    end
    else if (ca == 2) res = {a[31], 8'hFF, 23'd0};
    else if (cb == 2) res = {sb, 8'hFF, 23'd0};
    else if (ca == 0 && cb == 0) res = {a[31] & sb, 31'd0};
    else if (ca == 0) res = {sb, b[30:0]};
    else if (cb == 0) res = a;
    else byp = 1'b0;
  endfunction

  function automatic logic [31:0] pick_op();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0: r = 32'h0000_0000;
      1: r = 32'h8000_0000;
      2: r = 32'h7F80_0000;
      3: r = 32'hFF80_0000;
      4: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      5: r[30:23] = 8'h00;
      default: r[30:23] = 8'($urandom_range(1, 254));
    endcase
    return r;
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  // Random-phase model state
  beat_t       mq[$];
  beat_t       m_beat, nb;
  logic        m_valid, m_byp, m_inv_tmp, m_flag;
  logic [31:0] m_res;

  initial begin
    int acc, n_in, n_out, first_out, last_out, ready_pct;
    logic [31:0] exp_q[$];
    logic push, load;

    vecs[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b1, 32'h7FC0_0000, 1'b1};
    vecs[2]  = '{32'h0000_0000, 32'h4000_0000, 1'b1, 1'b1, 32'hC000_0000, 1'b0};
    vecs[3]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1'b1, 32'h7FC0_0000, 1'b0};
    vecs[4]  = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 1'b1, 32'h7FC0_0000, 1'b1};
    vecs[5]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b1, 32'h7F80_0000, 1'b0};
    vecs[6]  = '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 1'b1, 32'hFF80_0000, 1'b0};
    vecs[7]  = '{32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b1, 32'hFF80_0000, 1'b0};
    vecs[8]  = '{32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b0};
    vecs[9]  = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
    vecs[10] = '{32'h0000_0001, 32'h4040_0000, 1'b0, 1'b1, 32'h4040_0000, 1'b0};
    vecs[11] = '{32'hC000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'hC000_0000, 1'b0};
    vecs[12] = '{32'h3F80_0000, 32'h8000_0005, 1'b1, 1'b1, 32'h3F80_0000, 1'b0};
    vecs[13] = '{32'h7F80_0000, 32'h7F80_0001, 1'b1, 1'b1, 32'h7FC0_0000, 1'b0};

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_add_sub = 1'b0;
    i_clr_flags = 1'b0; i_32_a = '0; i_32_b = '0;
    @(negedge clk);
    tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_a", o_32_a, 32'd0);
    chk("rst_bypass", 32'(o_bypass), 32'd0);
    chk("rst_bres", o_32_bypass, 32'd0);
    chk("rst_flag", 32'(o_inv_flag), 32'd0);
    i_rst = 1'b0;

    // Classification table, one beat at a time
    i_ready = 1'b1;
    for (int v = 0; v < 14; v++) begin
      i_clr_flags = 1'b1;
      tick();
      i_clr_flags = 1'b0;
      i_valid = 1'b1; i_32_a = vecs[v].a; i_32_b = vecs[v].b; i_add_sub = vecs[v].op;
      tick();
      i_valid = 1'b0;
      chk("vec_lat0", 32'(o_valid), 32'd0);
      tick();
      chk("vec_valid", 32'(o_valid), 32'd1);
      chk("vec_a", o_32_a, vecs[v].a);
      chk("vec_b", o_32_b, vecs[v].b);
      chk("vec_op", 32'(o_add_sub), 32'(vecs[v].op));
      chk("vec_bypass", 32'(o_bypass), 32'(vecs[v].byp));
      chk("vec_bres", o_32_bypass, vecs[v].res);
      chk("vec_flag", 32'(o_inv_flag), 32'(vecs[v].inv));
      $display("vec %0d: a=%08h b=%08h op=%0d -> bypass=%0d res=%08h inv=%0d",
               v, o_32_a, o_32_b, o_add_sub, o_bypass, o_32_bypass, o_inv_flag);
      tick();
    end

    // Sticky flag: holds until cleared
    i_valid = 1'b1; i_32_a = 32'h7F80_0000; i_32_b = 32'h7F80_0000; i_add_sub = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (4) tick();
    chk("flag_hold", 32'(o_inv_flag), 32'd1);
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    chk("flag_clr", 32'(o_inv_flag), 32'd0);
    // Set and clear in the same cycle: set wins
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_clr_flags = 1'b1;
    tick();
    chk("flag_set_wins", 32'(o_inv_flag), 32'd1);
    tick();
    i_clr_flags = 1'b0;
    chk("flag_clr2", 32'(o_inv_flag), 32'd0);
    $display("flag sequence done");

    // Backpressure: DEPTH + 1 beats accepted, then drained in order
    i_ready = 1'b0; i_valid = 1'b1; i_32_b = 32'h4000_0000; i_add_sub = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      i_32_a = 32'h3F80_0000 + 32'(acc);
      if (o_ready) begin exp_q.push_back(i_32_a); acc++; end
      tick();
    end
    i_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'(DEPTH + 1));
    chk("bp_ready", 32'(o_ready), 32'd0);
    chk("bp_count", 32'(o_count), 32'(DEPTH));
    i_ready = 1'b1;
    for (int k = 0; k < acc; k++) begin
      chk("bp_drain_valid", 32'(o_valid), 32'd1);
      chk("bp_drain_a", o_32_a, exp_q[k]);
      tick();
    end
    chk("bp_empty", 32'(o_valid), 32'd0);
    $display("backpressure: accepted %0d beats", acc);

    // Reset mid-stream with 3 beats buffered
    i_ready = 1'b0; i_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_32_a = 32'h4100_0000 + 32'(c);
      tick();
    end
    i_valid = 1'b0;
    do_reset();
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_count", 32'(o_count), 32'd0);
    chk("mrst_ready", 32'(o_ready), 32'd1);
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("mrst_no_stale", 32'(o_valid), 32'd0);
      tick();
    end
    $display("mid-stream reset done");

    // Streaming 10 beats with continuous valid/ready
    n_in = 0; n_out = 0; first_out = -1; last_out = -1;
    for (int c = 0; c < 40 && n_out < 10; c++) begin
      if (o_valid) begin
        chk("stream_a", o_32_a, 32'd100 + 32'(n_out));
        if (first_out < 0) first_out = c;
        last_out = c;
        n_out++;
      end
      chk("stream_count_le1", 32'(o_count <= 1), 32'd1);
      i_valid = (n_in < 10);
      i_32_a = 32'd100 + 32'(n_in);
      if (i_valid && o_ready) n_in++;
      tick();
    end
    i_valid = 1'b0;
    chk("stream_n_out", 32'(n_out), 32'd10);
    chk("stream_span", 32'(last_out - first_out), 32'd9);
    $display("streaming: %0d beats out", n_out);

    // Randomized run against the reference model
    do_reset();
    mq.delete();
    m_valid = 1'b0; m_flag = 1'b0; m_byp = 1'b0; m_res = '0;
    m_beat = '{32'd0, 32'd0, 1'b0};
    ready_pct = 50;
    for (int c = 0; c < 600; c++) begin
      chk("rnd_valid", 32'(o_valid), 32'(m_valid));
      chk("rnd_ready", 32'(o_ready), 32'(mq.size() < DEPTH));
      chk("rnd_count", 32'(o_count), 32'(mq.size()));
      chk("rnd_flag", 32'(o_inv_flag), 32'(m_flag));
      if (m_valid) begin
        chk("rnd_a", o_32_a, m_beat.a);
        chk("rnd_b", o_32_b, m_beat.b);
        chk("rnd_op", 32'(o_add_sub), 32'(m_beat.op));
        chk("rnd_bypass", 32'(o_bypass), 32'(m_byp));
        chk("rnd_bres", o_32_bypass, m_res);
      end
      if (c % 60 == 0) ready_pct = $urandom_range(10, 100);
      i_valid     = ($urandom_range(0, 3) != 0);
      i_ready     = ($urandom_range(1, 100) <= ready_pct);
      i_clr_flags = ($urandom_range(0, 15) == 0);
      i_32_a      = pick_op();
      i_32_b      = pick_op();
      i_add_sub   = 1'($urandom_range(0, 1));
      push = i_valid && (mq.size() < DEPTH);
      load = (mq.size() > 0) && (!m_valid || i_ready);
      if (load) begin
        m_beat  = mq.pop_front();
        m_valid = 1'b1;
        ref_cls(m_beat.a, m_beat.b, m_beat.op, m_byp, m_res, m_inv_tmp);
      end else begin
        m_inv_tmp = 1'b0;
        if (i_ready) m_valid = 1'b0;
      end
      if (m_inv_tmp) m_flag = 1'b1;
      else if (i_clr_flags) m_flag = 1'b0;
      if (push) begin
        nb = '{i_32_a, i_32_b, i_add_sub};
        mq.push_back(nb);
      end
      tick();
    end
    $display("random phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
